axi4_lite_register_bank: RTL and testbench

AXI4_LITE_REGISTER_BANK -- requirements
Module: axi4_lite_register_bank

---
 rtl/axi4_lite_register_bank.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4_lite_register_bank.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_register_bank.sv
// AXI4-Lite slave exposing N_REGS byte-strobed registers, with per-register read-only inputs.
// Define AXI4_LITE_REGISTER_BANK_WR_PULSE_EN to add the wr_pulse output (one-cycle strobe per OKAY write).
module axi4_lite_register_bank #(
   parameter int                             DATA_WIDTH  = 32,
   parameter int                             ADDR_WIDTH  = 8,
   parameter int                             N_REGS      = 8,
   parameter logic [N_REGS-1:0]              RO_MASK     = '0,
   parameter logic [N_REGS*DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic                             aclk,
   input  logic                             areset_n,
   input  logic [ADDR_WIDTH-1:0]            awaddr,
   input  logic                             awvalid,
   output logic                             awready,
   input  logic [DATA_WIDTH-1:0]            wdata,
   input  logic [DATA_WIDTH/8-1:0]          wstrb,
   input  logic                             wvalid,
   output logic                             wready,
   output logic [1:0]                       bresp,
   output logic                             bvalid,
   input  logic                             bready,
   input  logic [ADDR_WIDTH-1:0]            araddr,
   input  logic                             arvalid,
   output logic                             arready,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic [1:0]                       rresp,
   output logic                             rvalid,
   input  logic                             rready,
   output logic [N_REGS*DATA_WIDTH-1:0]     reg_out,
   input  logic [N_REGS*DATA_WIDTH-1:0]     reg_in
`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
   ,
   output logic [N_REGS-1:0]                wr_pulse
`endif
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

   localparam logic [1:0] WR_COLLECT = 2'd0;
   localparam logic [1:0] WR_COMMIT  = 2'd1;
   localparam logic [1:0] WR_RESP    = 2'd2;

   localparam logic RD_IDLE = 1'b0;
   localparam logic RD_DATA = 1'b1;

   logic [1:0]            r_wrState;
   logic                  r_awFull;
   logic                  r_wFull;
   logic [IDX_W-1:0]      r_awIdx;
   logic [DATA_WIDTH-1:0] r_wData;
   logic [STRB_W-1:0]     r_wStrb;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   logic                  r_rdState;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   logic [DATA_WIDTH-1:0] r_regs [N_REGS];

   logic [1:0]            w_wrStateNxt;
   logic                  w_awFullNxt;
   logic                  w_wFullNxt;
   logic                  w_bvalidNxt;
   logic                  w_commit;
   logic [N_REGS-1:0]     w_wrSel;
   logic                  w_wrErr;
   logic [IDX_W-1:0]      w_rdIdx;
   logic [DATA_WIDTH-1:0] w_rdData;
   logic                  w_rdHit;
   logic                  w_unusedBits;

   // Ready flags are registered from next-state values so they stay in step with holder and bvalid state.
   always_comb begin
      w_wrStateNxt = r_wrState;
      w_awFullNxt  = r_awFull;
      w_wFullNxt   = r_wFull;
      w_bvalidNxt  = r_bvalid;
      w_commit     = 1'b0;
      if (awvalid && r_awready) w_awFullNxt = 1'b1;
      if (wvalid && r_wready)   w_wFullNxt  = 1'b1;
      case (r_wrState)
         WR_COLLECT: begin
            if (r_awFull && r_wFull) w_wrStateNxt = WR_COMMIT;
         end
         WR_COMMIT: begin
            w_commit     = 1'b1;
            w_wrStateNxt = WR_RESP;
            w_bvalidNxt  = 1'b1;
            w_awFullNxt  = 1'b0;
            w_wFullNxt   = 1'b0;
         end
         WR_RESP: begin
            if (bready) begin
               w_bvalidNxt  = 1'b0;
               w_wrStateNxt = WR_COLLECT;
            end
         end
         default: w_wrStateNxt = WR_COLLECT;
      endcase
   end

   always_comb begin
      w_wrSel = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (32'(r_awIdx) == 32'(i)) w_wrSel[i] = 1'b1;
      end
      w_wrErr = (~|w_wrSel) || (|(w_wrSel & RO_MASK));
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_wrState <= WR_COLLECT;
         r_awFull  <= 1'b0;
         r_wFull   <= 1'b0;
         r_awIdx   <= '0;
         r_wData   <= '0;
         r_wStrb   <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         r_wrState <= w_wrStateNxt;
         r_awFull  <= w_awFullNxt;
         r_wFull   <= w_wFullNxt;
         r_bvalid  <= w_bvalidNxt;
         r_awready <= !w_awFullNxt && !w_bvalidNxt;
         r_wready  <= !w_wFullNxt && !w_bvalidNxt;
         if (awvalid && r_awready) r_awIdx <= awaddr[ADDR_WIDTH-1:ADDR_LSB];
         if (wvalid && r_wready) begin
            r_wData <= wdata;
            r_wStrb <= wstrb;
         end
         if (w_commit) r_bresp <= w_wrErr ? 2'b10 : 2'b00;
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (w_commit && !w_wrErr) begin
         for (int i = 0; i < N_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (w_wrSel[i] && r_wStrb[b]) r_regs[i][b*8 +: 8] <= r_wData[b*8 +: 8];
            end
         end
      end
   end

`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
   logic [N_REGS-1:0] r_wrPulse;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_wrPulse <= '0;
      end else begin
         r_wrPulse <= (w_commit && !w_wrErr) ? w_wrSel : '0;
      end
   end

   assign wr_pulse = r_wrPulse;
`endif

   // Read data is captured at the AR handshake edge, so a same-cycle commit is not yet visible.
   always_comb begin
      w_rdIdx  = araddr[ADDR_WIDTH-1:ADDR_LSB];
      w_rdData = '0;
      w_rdHit  = 1'b0;
      for (int i = 0; i < N_REGS; i++) begin
         if (32'(w_rdIdx) == 32'(i)) begin
            w_rdHit  = 1'b1;
            w_rdData = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
         end
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_rdState <= RD_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= 2'b00;
      end else begin
         case (r_rdState)
            RD_IDLE: begin
               if (arvalid && r_arready) begin
                  r_rdState <= RD_DATA;
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= w_rdData;
                  r_rresp   <= w_rdHit ? 2'b00 : 2'b10;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            RD_DATA: begin
               if (rready) begin
                  r_rdState <= RD_IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
               end
            end
            default: begin
               r_rdState <= RD_IDLE;
               r_arready <= 1'b0;
               r_rvalid  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_regOut
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
   end

   assign w_unusedBits = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0], reg_in};

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bresp   = r_bresp;
   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_register_bank.sv
// Directed bench for axi4_lite_register_bank: reg 7 read-only, reg 2 resets to zero, others to A5A5_000i.
module tb_axi4_lite_register_bank;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam logic [NR-1:0] RO = 8'h80;
   localparam logic [NR*DW-1:0] RV = {32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
                                      32'hA5A5_0003, 32'h0000_0000, 32'hA5A5_0001, 32'hA5A5_0000};

   logic              aclk = 1'b0;
   logic              areset_n = 1'b1;
   logic [7:0]        awaddr = '0;
   logic              awvalid = 1'b0;
   logic              awready;
   logic [31:0]       wdata = '0;
   logic [3:0]        wstrb = '0;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready = 1'b0;
   logic [7:0]        araddr = '0;
   logic              arvalid = 1'b0;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready = 1'b0;
   logic [NR*DW-1:0]  reg_out;
   logic [NR*DW-1:0]  reg_in = {32'h7777_1234, 32'hBAD0_0006, 32'hBAD0_0005, 32'hBAD0_0004,
                                32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
   logic [NR-1:0]     wr_pulse;
`endif

   int vectors = 0;
   int miscompares = 0;

   axi4_lite_register_bank #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (8),
      .N_REGS     (NR),
      .RO_MASK    (RO),
      .RESET_VALUE(RV)
   ) dut (
      .aclk    (aclk),
      .areset_n(areset_n),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .reg_out (reg_out),
      .reg_in  (reg_in)
`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
      ,
      .wr_pulse(wr_pulse)
`endif
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] regOutSlice(input int idx);
      return reg_out[idx*DW +: DW];
   endfunction

   task automatic doWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
      logic awHs;
      logic wHs;
      logic done;
      int cyc;
      resp = 2'b11;
      @(posedge aclk); #1;
      awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
      cyc = 0;
      while ((awvalid || wvalid) && cyc < 50) begin
         @(negedge aclk);
         awHs = awvalid && awready;
         wHs  = wvalid && wready;
         @(posedge aclk); #1;
         if (awHs) awvalid = 1'b0;
         if (wHs)  wvalid  = 1'b0;
         cyc++;
      end
      done = 1'b0;
      while (!done && cyc < 50) begin
         @(negedge aclk);
         if (bvalid) begin
            resp = bresp;
            done = 1'b1;
         end
         cyc++;
      end
      @(posedge aclk); #1;
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      if (!done) begin
         vectors++; miscompares++;
         $display("[TB] FAIL write_timeout addr=%h: got no bvalid, required one within 50 cycles", addr);
      end
   endtask

   task automatic doRead(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic hs;
      logic done;
      int cyc;
      data = 32'hFFFF_FFFF;
      resp = 2'b11;
      @(posedge aclk); #1;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      cyc = 0;
      while (arvalid && cyc < 50) begin
         @(negedge aclk);
         hs = arready;
         @(posedge aclk); #1;
         if (hs) arvalid = 1'b0;
         cyc++;
      end
      done = 1'b0;
      while (!done && cyc < 50) begin
         @(negedge aclk);
         if (rvalid) begin
            data = rdata;
            resp = rresp;
            done = 1'b1;
         end
         cyc++;
      end
      @(posedge aclk); #1;
      rready = 1'b0; arvalid = 1'b0;
      if (!done) begin
         vectors++; miscompares++;
         $display("[TB] FAIL read_timeout addr=%h: got no rvalid, required one within 50 cycles", addr);
      end
   endtask

   // Reset values, ready rise one edge after release, and a read of every index.
   task automatic test_reset;
      logic [31:0] d;
      logic [1:0]  r;
      logic [31:0] expRd [NR] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'h0000_0000, 32'hA5A5_0003,
                                  32'hA5A5_0004, 32'hA5A5_0005, 32'hA5A5_0006, 32'h7777_1234};
      #2 areset_n = 1'b0;
      #1;
      vectors++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl got %b expected %b", {awready, wready, arready, bvalid, rvalid}, 5'b0);
      end
      vectors++;
      if ({rdata, rresp, bresp} !== 36'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data got %h expected 0", {rdata, rresp, bresp});
      end
      vectors++;
      if (reg_out !== RV) begin
         miscompares++;
         $display("[TB] FAIL reset_regout got %h expected %h", reg_out, RV);
      end
      repeat (2) @(negedge aclk);
      areset_n = 1'b1;
      #1;
      vectors++;
      if (arready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL arready_before_edge got %b expected 0", arready);
      end
      @(negedge aclk);
      vectors++;
      if ({awready, wready, arready} !== 3'b111) begin
         miscompares++;
         $display("[TB] FAIL ready_after_release got %b expected 111", {awready, wready, arready});
      end
      for (int i = 0; i < NR; i++) begin
         doRead(8'(i * 4), d, r);
         vectors++;
         if ({d, r} !== {expRd[i], 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL reset_read idx=%0d got %h/%b expected %h/00", i, d, r, expRd[i]);
         end
      end
   endtask

   task automatic test_strobe_write;
      logic [31:0] d;
      logic [1:0]  r;
      doWrite(8'h08, 32'hDEAD_BEEF, 4'b0101, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL strobe_bresp got %b expected 00", r);
      end
      doRead(8'h08, d, r);
      vectors++;
      if ({d, r} !== {32'h00AD_00EF, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL strobe_read got %h/%b expected 00ad00ef/00", d, r);
      end
      doRead(8'h0B, d, r);
      vectors++;
      if (d !== 32'h00AD_00EF) begin
         miscompares++;
         $display("[TB] FAIL low_addr_ignored got %h expected 00ad00ef", d);
      end
   endtask

   // Two-cycle AW+W to bvalid latency, reg_out timing, and the write pulse.
   task automatic test_latency;
      @(posedge aclk); #1;
      awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(negedge aclk);
      vectors++;
      if ({awready, wready} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL latency_ready got %b expected 11", {awready, wready});
      end
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      vectors++;
      if (bvalid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_c1 bvalid got %b expected 0", bvalid);
      end
      @(negedge aclk);
      vectors++;
      if ({bvalid, regOutSlice(1)} !== {1'b0, 32'hA5A5_0001}) begin
         miscompares++;
         $display("[TB] FAIL latency_c2 bvalid/reg1 got %b/%h expected 0/a5a50001", bvalid, regOutSlice(1));
      end
`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
      vectors++;
      if (wr_pulse !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL pulse_early got %h expected 00", wr_pulse);
      end
`endif
      @(negedge aclk);
      vectors++;
      if ({bvalid, bresp, regOutSlice(1)} !== {1'b1, 2'b00, 32'h1122_3344}) begin
         miscompares++;
         $display("[TB] FAIL latency_c3 bvalid/bresp/reg1 got %b/%b/%h expected 1/00/11223344",
                  bvalid, bresp, regOutSlice(1));
      end
`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
      vectors++;
      if (wr_pulse !== 8'h02) begin
         miscompares++;
         $display("[TB] FAIL pulse_on got %h expected 02", wr_pulse);
      end
`endif
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
      vectors++;
      if (bvalid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_bdone got %b expected 0", bvalid);
      end
`ifdef AXI4_LITE_REGISTER_BANK_WR_PULSE_EN
      vectors++;
      if (wr_pulse !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL pulse_off got %h expected 00", wr_pulse);
      end
`endif
   endtask

   task automatic test_w_before_aw;
      logic [31:0] d;
      logic [1:0]  r;
      int bCount;
      @(posedge aclk); #1;
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      @(negedge aclk);
      vectors++;
      if (wready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wfirst_wready got %b expected 1", wready);
      end
      @(posedge aclk); #1;
      wvalid = 1'b0;
      @(negedge aclk);
      vectors++;
      if ({wready, awready, bvalid} !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL wfirst_hold got %b expected 010", {wready, awready, bvalid});
      end
      repeat (2) @(posedge aclk);
      #1;
      awaddr = 8'h0C; awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      bCount = 0;
      repeat (8) begin
         @(negedge aclk);
         if (bvalid) bCount++;
      end
      bready = 1'b0;
      vectors++;
      if (bCount !== 1) begin
         miscompares++;
         $display("[TB] FAIL wfirst_bcount got %0d expected 1", bCount);
      end
      doRead(8'h0C, d, r);
      vectors++;
      if (d !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("[TB] FAIL wfirst_read got %h expected cafef00d", d);
      end
   endtask

   task automatic test_errors;
      logic [31:0] d;
      logic [1:0]  r;
      logic [NR*DW-1:0] expRegs = {32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
                                   32'hCAFE_F00D, 32'h00AD_00EF, 32'h1122_3344, 32'hA5A5_0000};
      doWrite(8'h20, 32'hFFFF_FFFF, 4'hF, r);
      vectors++;
      if (r !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL oor_write_bresp got %b expected 10", r);
      end
      doWrite(8'hFC, 32'hFFFF_FFFF, 4'hF, r);
      vectors++;
      if (r !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL top_addr_bresp got %b expected 10", r);
      end
      doWrite(8'h1C, 32'hFFFF_FFFF, 4'hF, r);
      vectors++;
      if (r !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL ro_write_bresp got %b expected 10", r);
      end
      doWrite(8'h00, 32'h1234_5678, 4'h0, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL zero_strb_bresp got %b expected 00", r);
      end
      vectors++;
      if (reg_out !== expRegs) begin
         miscompares++;
         $display("[TB] FAIL err_contents got %h expected %h", reg_out, expRegs);
      end
      doRead(8'h20, d, r);
      vectors++;
      if ({d, r} !== {32'h0, 2'b10}) begin
         miscompares++;
         $display("[TB] FAIL oor_read got %h/%b expected 00000000/10", d, r);
      end
      doRead(8'h1C, d, r);
      vectors++;
      if ({d, r} !== {32'h7777_1234, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL ro_read got %h/%b expected 77771234/00", d, r);
      end
   endtask

   task automatic test_bready_stall;
      logic [31:0] d;
      logic [1:0]  r;
      int cyc;
      @(posedge aclk); #1;
      awaddr = 8'h10; awvalid = 1'b1; wdata = 32'h4444_5555; wstrb = 4'b0011; wvalid = 1'b1; bready = 1'b0;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      cyc = 0;
      while (!bvalid && cyc < 20) begin
         @(negedge aclk);
         cyc++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         vectors++;
         if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL stall_cycle%0d got %b expected 10000", k, {bvalid, bresp, awready, wready});
         end
      end
      @(posedge aclk); #1;
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
      vectors++;
      if ({bvalid, awready} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL stall_release got %b expected 01", {bvalid, awready});
      end
      doWrite(8'h14, 32'h0BAD_F00D, 4'hF, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL second_write_bresp got %b expected 00", r);
      end
      doRead(8'h10, d, r);
      vectors++;
      if (d !== 32'hA5A5_5555) begin
         miscompares++;
         $display("[TB] FAIL stall_read4 got %h expected a5a55555", d);
      end
      doRead(8'h14, d, r);
      vectors++;
      if (d !== 32'h0BAD_F00D) begin
         miscompares++;
         $display("[TB] FAIL stall_read5 got %h expected 0badf00d", d);
      end
   endtask

   // AR handshake lands on the commit edge of a write to the same register.
   task automatic test_same_cycle;
      logic [31:0] d;
      logic [1:0]  r;
      @(posedge aclk); #1;
      awaddr = 8'h18; awvalid = 1'b1; wdata = 32'h6666_6666; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge aclk); #1;
      araddr = 8'h18; arvalid = 1'b1; rready = 1'b1;
      @(negedge aclk);
      vectors++;
      if (arready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_arready got %b expected 1", arready);
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      @(negedge aclk);
      vectors++;
      if ({rvalid, rdata, bvalid} !== {1'b1, 32'hA5A5_0006, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_read got rvalid=%b rdata=%h bvalid=%b expected 1/a5a50006/1",
                  rvalid, rdata, bvalid);
      end
      @(posedge aclk); #1;
      rready = 1'b0; bready = 1'b0;
      doRead(8'h18, d, r);
      vectors++;
      if (d !== 32'h6666_6666) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_after got %h expected 66666666", d);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      @(posedge aclk); #1;
      awaddr = 8'h10; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      @(negedge aclk);
      areset_n = 1'b0;
      #1;
      vectors++;
      if ({wready, awready, bvalid} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL midreset_async got %b expected 000", {wready, awready, bvalid});
      end
      vectors++;
      if ({regOutSlice(2), regOutSlice(4)} !== {32'h0, 32'hA5A5_0004}) begin
         miscompares++;
         $display("[TB] FAIL midreset_regs got %h/%h expected 00000000/a5a50004", regOutSlice(2), regOutSlice(4));
      end
      @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk); #1;
      wdata = 32'hDEAD_DEAD; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge aclk); #1;
      wvalid = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge aclk);
         if (bvalid) seen = 1'b1;
      end
      bready = 1'b0;
      vectors++;
      if ({seen, awready, wready} !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL midreset_nobvalid got seen/awready/wready=%b expected 010", {seen, awready, wready});
      end
      vectors++;
      if (regOutSlice(4) !== 32'hA5A5_0004) begin
         miscompares++;
         $display("[TB] FAIL midreset_reg4 got %h expected a5a50004", regOutSlice(4));
      end
   endtask

   initial begin
      test_reset();
      test_strobe_write();
      test_latency();
      test_w_before_aw();
      test_errors();
      test_bready_stall();
      test_same_cycle();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
